// File: rtl/pwm_breather.sv
// pwm_breather: "breathing" duty sequencer for the downstream LED pwm block.
// It produces the pwm step tick and keeps a mirror of the pwm period counter.
// Duty then changes only on the clk after a period wrap, so the pwm sees the
// new value from counter value 0 and never truncates a period.
// STEP_DIV must be at least 2 so that the new duty settles before the next step.
module pwm_breather #(
    parameter int N        = 8,
    parameter int STEP_DIV = 16,
    parameter int RATE_W   = 8,
    parameter int HOLD_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [RATE_W-1:0] rate,
    input  logic [HOLD_W-1:0] hold_lo,
    input  logic [HOLD_W-1:0] hold_hi,
    output logic              step,
    output logic [N-1:0]      duty,
    output logic              period_done,
    output logic [1:0]        phase
);

    localparam int                 PRESC_W    = $clog2(STEP_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [N-1:0]       DUTY_MAX   = {N{1'b1}};

    typedef enum logic [1:0] {
        HOLD_LO = 2'd0,
        UP      = 2'd1,
        HOLD_HI = 2'd2,
        DOWN    = 2'd3
    } state_t;

    state_t              state;
    logic [PRESC_W-1:0]  presc;
    logic [N-1:0]        mirror;
    logic [RATE_W-1:0]   rate_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                clear;
    logic                presc_wrap;
    logic [N-1:0]        duty_up;
    logic [N-1:0]        duty_dn;

    // Saturating duty moves: duty can never wrap past either extreme.
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] d);
        return (d == DUTY_MAX) ? DUTY_MAX : d + 1'b1;
    endfunction

    function automatic logic [N-1:0] sat_dec(input logic [N-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // ena low clears everything, exactly like the downstream pwm does.
    assign clear      = rst | ~ena;
    assign presc_wrap = (presc == PRESC_LAST);
    assign duty_up    = sat_inc(duty);
    assign duty_dn    = sat_dec(duty);
    assign phase      = state;

    // Prescaler, step tick and mirror of the downstream pwm period counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            presc       <= '0;
            mirror      <= '0;
            step        <= 1'b0;
            period_done <= 1'b0;
        end else begin
            step        <= presc_wrap;
            period_done <= presc_wrap && (mirror == DUTY_MAX);
            if (presc_wrap) begin
                presc  <= '0;
                mirror <= mirror + 1'b1;
            end else begin
                presc  <= presc + 1'b1;
            end
        end
    end

    // Breathing FSM: advances once per pwm period, on the period_done clk.
    // The >= compares let a live reduction of rate/hold take effect at the
    // very next period boundary instead of waiting for a counter wrap.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= HOLD_LO;
            duty     <= '0;
            rate_cnt <= '0;
            hold_cnt <= '0;
        end else if (period_done) begin
            case (state)
                HOLD_LO: begin
                    if (hold_cnt >= hold_lo) begin
                        state    <= UP;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                UP: begin
                    if (rate_cnt >= rate) begin
                        rate_cnt <= '0;
                        duty     <= duty_up;
                        if (duty_up == DUTY_MAX) begin
                            state <= HOLD_HI;
                        end
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt >= hold_hi) begin
                        state    <= DOWN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (rate_cnt >= rate) begin
                        rate_cnt <= '0;
                        duty     <= duty_dn;
                        if (duty_dn == '0) begin
                            state <= HOLD_LO;
                        end
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
                default: state <= HOLD_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_breather.sv
// tb_pwm_breather: scoreboard bench for pwm_breather.
// Expected (duty, phase) per pwm period comes from the dwell rules and is
// queued up front. Each period_done pops one entry and compares it.
// A second instance with N=8 covers the step/duty timing against a wider pwm.
module tb_pwm_breather;

    localparam int N   = 4;
    localparam int SD  = 2;
    localparam int RW  = 8;
    localparam int HW  = 8;
    localparam int N8  = 8;
    localparam int MAXD = (1 << N) - 1;
    localparam int PER  = (1 << N) * SD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ena;
    logic [RW-1:0] rate;
    logic [HW-1:0] hold_lo, hold_hi;
    logic          step, period_done;
    logic [N-1:0]  duty;
    logic [1:0]    phase;

    logic          rst8, ena8;
    logic [RW-1:0] rate8;
    logic [HW-1:0] hold_lo8, hold_hi8;
    logic          step8, period_done8;
    logic [N8-1:0] duty8;
    logic [1:0]    phase8;

    pwm_breather #(.N(N), .STEP_DIV(SD), .RATE_W(RW), .HOLD_W(HW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rate(rate),
        .hold_lo(hold_lo), .hold_hi(hold_hi),
        .step(step), .duty(duty), .period_done(period_done), .phase(phase)
    );

    pwm_breather #(.N(N8), .STEP_DIV(SD), .RATE_W(RW), .HOLD_W(HW)) dut8 (
        .clk(clk), .rst(rst8), .ena(ena8), .rate(rate8),
        .hold_lo(hold_lo8), .hold_hi(hold_hi8),
        .step(step8), .duty(duty8), .period_done(period_done8), .phase(phase8)
    );

    typedef struct packed {
        logic [N-1:0] duty;
        logic [1:0]   phase;
    } exp_t;

    exp_t sb[$];
    int   pd_cycles[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_n(input int v, input int ph, input int n);
        exp_t e;
        e.duty  = N'(v);
        e.phase = 2'(ph);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // One full breath from the dwell rules, period by period.
    task automatic push_breath(input int r, input int hl, input int hh);
        push_n(0, 0, hl + 1);
        push_n(0, 1, r + 1);
        for (int v = 1; v < MAXD; v++) push_n(v, 1, r + 1);
        push_n(MAXD, 2, hh + 1);
        push_n(MAXD, 3, r + 1);
        for (int v = MAXD - 1; v >= 1; v--) push_n(v, 3, r + 1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_outputs", int'({duty, step, period_done, phase}), 0);
        end
        rst = 1'b0;
    endtask

    // Run until np period_done pulses have been seen, scoring each period.
    task automatic run_periods(input int np);
        int   seen = 0;
        int   budget = np * PER + 8 * SD;
        logic prev_pd = period_done;
        logic [N-1:0] prev_d = duty;
        bit   have_step = 0, have_pd = 0;
        int   last_step = 0, last_pd = 0;
        exp_t e;
        while (seen < np) begin
            tick();
            budget--;
            if (budget < 0) begin
                chk("run_timeout", seen, np);
                return;
            end
            if (duty !== prev_d) chk("duty_chg_after_pd", int'(prev_pd), 1);
            if (step) begin
                if (have_step) chk("step_gap", cyc - last_step, SD);
                have_step = 1;
                last_step = cyc;
            end
            if (period_done) begin
                chk("pd_with_step", int'(step), 1);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("duty", int'(duty), int'(e.duty));
                    chk("phase", int'(phase), int'(e.phase));
                end
                if (have_pd) chk("pd_gap", cyc - last_pd, PER);
                have_pd = 1;
                last_pd = cyc;
                pd_cycles.push_back(cyc);
                seen++;
            end
            prev_pd = period_done;
            prev_d  = duty;
        end
    endtask

    task automatic wait_pd8(output bit ok);
        ok = 0;
        for (int k = 0; k < 1200; k++) begin
            tick();
            if (period_done8) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int first_step, first_pd, nsteps, t0, np;
        bit found, ok;
        int exp_after[3]  = '{0, 1, 2};
        int exp_before[3] = '{0, 0, 1};

        rst = 1'b1; ena = 1'b1; rate = '0; hold_lo = '0; hold_hi = '0;
        rst8 = 1'b1; ena8 = 1'b1; rate8 = '0; hold_lo8 = '0; hold_hi8 = '0;

        // Reset and first-step / first-period latency.
        do_reset(3);
        first_step = -1; first_pd = -1; nsteps = 0;
        for (int k = 1; k <= 40 && first_pd < 0; k++) begin
            tick();
            if (step) begin
                nsteps++;
                if (first_step < 0) first_step = k;
            end
            if (period_done) first_pd = k;
        end
        chk("first_step_clks", first_step, 2);
        chk("first_pd_clks", first_pd, 32);
        chk("steps_to_first_pd", nsteps, 16);

        // Ramp with holds: rate 0, hold_lo 0, hold_hi 1.
        hold_hi = 8'd1;
        do_reset(2);
        t0 = cyc;
        sb.delete();
        pd_cycles.delete();
        push_breath(0, 0, 1);
        chk("breath_periods", sb.size(), 33);
        push_n(0, 0, 1);
        run_periods(34);
        if (pd_cycles.size() >= 33) chk("breath_clks", pd_cycles[32] - t0, 1056);
        else chk("breath_pd_count", pd_cycles.size(), 34);

        // Rate dwell: rate 2, no holds.
        rate = 8'd2; hold_lo = '0; hold_hi = '0;
        do_reset(2);
        sb.delete();
        push_breath(2, 0, 0);
        push_n(0, 0, 1);
        np = sb.size();
        run_periods(np);

        // Enable drop in DOWN at duty 9.
        rate = '0;
        do_reset(2);
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            tick();
            if (phase == 2'd3 && duty == N'(9)) found = 1;
        end
        chk("find_down_9", int'(found), 1);
        ena = 1'b0;
        tick();
        chk("ena_drop_outputs", int'({duty, step, period_done, phase}), 0);
        ena = 1'b1;
        tick();
        chk("ena_rise_step_1", int'(step), 0);
        tick();
        chk("ena_rise_step_2", int'(step), 1);
        sb.delete();
        push_n(0, 0, 1);
        push_n(0, 1, 1);
        push_n(1, 1, 1);
        run_periods(3);

        // Live rate change from 5 to 0 with rate_cnt at 4.
        rate = 8'd5;
        do_reset(2);
        sb.delete();
        push_n(0, 0, 1);
        push_n(0, 1, 4);
        run_periods(5);
        tick();
        chk("live_rate_hold", int'(duty), 0);
        rate = '0;
        push_n(0, 1, 1);
        push_n(1, 1, 1);
        push_n(2, 1, 1);
        run_periods(3);

        // N=8 instance: duty versus wrap step, then reset on the period_done clk.
        rst8 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_pd8(ok);
            chk("n8_pd_seen", int'(ok), 1);
            chk("n8_step_at_wrap", int'(step8), 1);
            chk("n8_duty_at_wrap", int'(duty8), exp_before[p]);
            tick();
            chk("n8_duty_next_clk", int'(duty8), exp_after[p]);
            chk("n8_no_step_next_clk", int'(step8), 0);
            tick();
            chk("n8_step_after_update", int'(step8), 1);
            chk("n8_duty_stable", int'(duty8), exp_after[p]);
        end
        chk("n8_phase_up", int'(phase8), 1);
        wait_pd8(ok);
        chk("n8_pd_seen_rst", int'(ok), 1);
        rst8 = 1'b1;
        tick();
        chk("n8_rst_on_pd", int'({duty8, period_done8, phase8}), 0);
        rst8 = 1'b0;
        tick();
        chk("n8_rst_after_duty", int'(duty8), 0);
        chk("n8_rst_after_phase", int'(phase8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
